// File: rtl/sprite_motion_ctrl.sv
// Sprite motion controller: once per video frame, reads the WASD keycode, moves the sprite
// within screen bounds and picks the sprite-sheet frame as {facing row, animation column}.
module sprite_motion_ctrl #(
   parameter int unsigned X_MIN    = 0,
   parameter int unsigned X_MAX    = 640,
   parameter int unsigned Y_MIN    = 0,
   parameter int unsigned Y_MAX    = 480,
   parameter int unsigned SPR_W    = 32,
   parameter int unsigned SPR_H    = 52,
   parameter int unsigned STEP     = 2,
   parameter int unsigned ANIM_DIV = 8,
   parameter int unsigned X_START  = 304,
   parameter int unsigned Y_START  = 214
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   output logic [9:0] shape_x,
   output logic [9:0] shape_y,
   output logic [3:0] sel,
   output logic       walking
);

   localparam logic [10:0] L_STEP   = 11'(STEP);
   localparam logic [10:0] L_X_LO   = 11'(X_MIN);
   localparam logic [10:0] L_X_LIM  = 11'(X_MIN + STEP);
   localparam logic [10:0] L_X_HI   = 11'(X_MAX - SPR_W);
   localparam logic [10:0] L_Y_LO   = 11'(Y_MIN);
   localparam logic [10:0] L_Y_LIM  = 11'(Y_MIN + STEP);
   localparam logic [10:0] L_Y_HI   = 11'(Y_MAX - SPR_H);
   localparam logic [7:0]  L_A_LAST = 8'(ANIM_DIV - 1);

   typedef enum logic {StIdle, StWalk} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_sync1, r_sync2, r_prev;
   logic [9:0]  r_x, r_y, w_x_nxt, w_y_nxt;
   logic [1:0]  r_row, r_col, w_row_nxt, w_col_nxt;
   logic [7:0]  r_anim, w_anim_nxt;
   logic        r_walking;
   logic        w_tick;
   logic        w_dir_vld;
   logic [1:0]  w_dir;
   logic [10:0] w_x11, w_y11;
   logic [10:0] w_x_left, w_x_right, w_y_up, w_y_down;
   logic [9:0]  w_mx, w_my;

   assign w_tick = r_sync2 & ~r_prev;

   // Row encoding matches the sprite sheet: 0 down, 1 left, 2 right, 3 up.
   always_comb begin
      w_dir_vld = 1'b1;
      w_dir     = 2'd0;
      case (keycode)
         8'h16:   w_dir = 2'd0;
         8'h04:   w_dir = 2'd1;
         8'h07:   w_dir = 2'd2;
         8'h1A:   w_dir = 2'd3;
         default: w_dir_vld = 1'b0;
      endcase
   end

   // 11-bit intermediates keep the clamp compares free of wrap-around.
   assign w_x11     = {1'b0, r_x};
   assign w_y11     = {1'b0, r_y};
   assign w_x_left  = (w_x11 < L_X_LIM) ? L_X_LO : w_x11 - L_STEP;
   assign w_x_right = (w_x11 + L_STEP > L_X_HI) ? L_X_HI : w_x11 + L_STEP;
   assign w_y_up    = (w_y11 < L_Y_LIM) ? L_Y_LO : w_y11 - L_STEP;
   assign w_y_down  = (w_y11 + L_STEP > L_Y_HI) ? L_Y_HI : w_y11 + L_STEP;

   always_comb begin
      w_mx = r_x;
      w_my = r_y;
      case (w_dir)
         2'd0: w_my = w_y_down[9:0];
         2'd1: w_mx = w_x_left[9:0];
         2'd2: w_mx = w_x_right[9:0];
         2'd3: w_my = w_y_up[9:0];
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_anim_nxt  = r_anim;
      if (w_tick) begin
         case (r_state)
            StIdle: begin
               if (w_dir_vld) begin
                  w_state_nxt = StWalk;
                  w_row_nxt   = w_dir;
                  w_col_nxt   = 2'd0;
                  w_anim_nxt  = 8'd0;
                  w_x_nxt     = w_mx;
                  w_y_nxt     = w_my;
               end
            end
            StWalk: begin
               if (!w_dir_vld) begin
                  w_state_nxt = StIdle;
                  w_col_nxt   = 2'd0;
                  w_anim_nxt  = 8'd0;
               end else if (w_dir == r_row) begin
                  w_x_nxt = w_mx;
                  w_y_nxt = w_my;
                  if (r_anim == L_A_LAST) begin
                     w_col_nxt  = r_col + 2'd1;
                     w_anim_nxt = 8'd0;
                  end else begin
                     w_anim_nxt = r_anim + 8'd1;
                  end
               end else begin
                  w_row_nxt  = w_dir;
                  w_col_nxt  = 2'd0;
                  w_anim_nxt = 8'd0;
                  w_x_nxt    = w_mx;
                  w_y_nxt    = w_my;
               end
            end
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_prev    <= 1'b0;
         r_state   <= StIdle;
         r_x       <= 10'(X_START);
         r_y       <= 10'(Y_START);
         r_row     <= 2'd0;
         r_col     <= 2'd0;
         r_anim    <= 8'd0;
         r_walking <= 1'b0;
      end else begin
         r_sync1   <= frame_clk;
         r_sync2   <= r_sync1;
         r_prev    <= r_sync2;
         r_state   <= w_state_nxt;
         r_x       <= w_x_nxt;
         r_y       <= w_y_nxt;
         r_row     <= w_row_nxt;
         r_col     <= w_col_nxt;
         r_anim    <= w_anim_nxt;
         r_walking <= (w_state_nxt == StWalk);
      end
   end

   assign shape_x = r_x;
   assign shape_y = r_y;
   assign sel     = {r_row, r_col};
   assign walking = r_walking;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: instance A uses default STEP, instance B uses STEP=3.
module tb_sprite_motion_ctrl;

   typedef struct {
      int ax, ay, asel, aw;
      int bx, by, bsel, bw;
   } exp_t;

   logic       Clk, Reset_n, frame_clk, clk_run;
   logic [7:0] key_a, key_b;
   logic [9:0] ax, ay, bx, by;
   logic [3:0] asel, bsel;
   logic       aw, bw;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   exp_t prev;

   sprite_motion_ctrl u_dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(key_a),
      .shape_x(ax), .shape_y(ay), .sel(asel), .walking(aw)
   );

   sprite_motion_ctrl #(.STEP(3)) u_dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(key_b),
      .shape_x(bx), .shape_y(by), .sel(bsel), .walking(bw)
   );

   always begin
      #10;
      if (clk_run) Clk = ~Clk;
   end

   function automatic exp_t rst_e();
      exp_t e;
      e.ax = 304; e.ay = 214; e.asel = 0; e.aw = 0;
      e.bx = 304; e.by = 214; e.bsel = 0; e.bw = 0;
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic compare_all(input string tag, input exp_t e);
      chk({tag, " a.shape_x"}, int'(ax), e.ax);
      chk({tag, " a.shape_y"}, int'(ay), e.ay);
      chk({tag, " a.sel"}, int'(asel), e.asel);
      chk({tag, " a.walking"}, int'(aw), e.aw);
      chk({tag, " b.shape_x"}, int'(bx), e.bx);
      chk({tag, " b.shape_y"}, int'(by), e.by);
      chk({tag, " b.sel"}, int'(bsel), e.bsel);
      chk({tag, " b.walking"}, int'(bw), e.bw);
   endtask

   task automatic frame(input logic [7:0] ka, input logic [7:0] kb, input exp_t e,
                        input int hold);
      @(negedge Clk);
      key_a = ka;
      key_b = kb;
      exp_q.push_back(e);
      frame_clk = 1'b1;
      repeat (hold) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (7) @(negedge Clk);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      compare_all("reset", rst_e());
      @(negedge Clk);
      Reset_n = 1'b1;
      prev = rst_e();
   endtask

   // Monitor: unchanged after edge 2, updated on edge 3, held after frame_clk falls.
   initial begin
      exp_t cur;
      forever begin
         @(posedge frame_clk);
         repeat (2) @(posedge Clk);
         #1;
         compare_all("pre", prev);
         @(posedge Clk);
         #1;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: DUT update with no expected entry (t=%0t)", $time);
         end else begin
            cur = exp_q.pop_front();
            compare_all("post", cur);
            prev = cur;
         end
         @(negedge frame_clk);
         repeat (4) @(posedge Clk);
         #1;
         compare_all("hold", prev);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   v;
      Clk = 1'b0; clk_run = 1'b0; Reset_n = 1'b1; frame_clk = 1'b0;
      key_a = 8'h00; key_b = 8'h00;

      // Reset with the clock stopped.
      #5 Reset_n = 1'b0;
      #1 compare_all("reset clk stopped", rst_e());
      #4 Reset_n = 1'b1;
      prev = rst_e();
      clk_run = 1'b1;

      // Non-direction key in IDLE: nothing changes.
      frame(8'h55, 8'h00, rst_e(), 4);

      // Walk right: latency/single tick on the first, animation cadence through a wrap.
      for (int k = 1; k <= 41; k++) begin
         e = rst_e();
         e.ax = 304 + 2 * k; e.asel = 8 + ((k - 1) / 8) % 4; e.aw = 1;
         frame(8'h07, 8'h00, e, (k == 1) ? 10 : 4);
      end
      e = rst_e(); e.ax = 386; e.asel = 8; e.aw = 0;
      frame(8'h00, 8'h00, e, 4);

      // Walk left into the left edge, exact clamp at 0.
      do_reset();
      for (int k = 1; k <= 200; k++) begin
         v = 304 - 2 * k;
         if (v < 0) v = 0;
         e = rst_e(); e.ax = v; e.asel = 4 + ((k - 1) / 8) % 4; e.aw = 1;
         frame(8'h04, 8'h00, e, 4);
      end

      // Down, then reverse to up, then release.
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         e = rst_e(); e.ay = 214 + 2 * k; e.asel = ((k - 1) / 8) % 4; e.aw = 1;
         frame(8'h16, 8'h00, e, 4);
      end
      e = rst_e(); e.ay = 232; e.asel = 12; e.aw = 1;
      frame(8'h1A, 8'h00, e, 4);
      e.aw = 0;
      frame(8'h00, 8'h00, e, 4);

      // Reset mid-walk, between clock edges, then restart from IDLE.
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         e = rst_e(); e.ax = 304 + 2 * k; e.asel = 8 + ((k - 1) / 8) % 4; e.aw = 1;
         frame(8'h07, 8'h00, e, 4);
      end
      @(posedge Clk);
      #4 Reset_n = 1'b0;
      #1 compare_all("reset mid-walk", rst_e());
      @(negedge Clk);
      Reset_n = 1'b1;
      prev = rst_e();
      e = rst_e(); e.ay = 212; e.asel = 12; e.aw = 1;
      frame(8'h1A, 8'h00, e, 4);

      // STEP=3 instance: non-exact clamp at 608 on the right edge.
      do_reset();
      for (int k = 1; k <= 110; k++) begin
         v = 304 + 3 * k;
         if (v > 608) v = 608;
         e = rst_e(); e.bx = v; e.bsel = 8 + ((k - 1) / 8) % 4; e.bw = 1;
         frame(8'h00, 8'h07, e, 4);
      end

      chk("scoreboard drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
